// File: rtl/axi4_lite_master_gen2_if.sv
// AXI4-Lite channel bundle between the master and the interconnect.
interface axi4_lite_master_gen2_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  // Every channel uses the same handshake. A transfer happens on the rising
  // edge where VALID and READY are both high. A VALID, once raised, is held
  // with its payload stable until that edge. A READY may rise or fall freely.
  logic [ADDRESS-1:0]    M_ARADDR;
  logic                  M_ARVALID;
  logic                  M_ARREADY;
  logic [DATA_WIDTH-1:0] M_RDATA;
  logic [1:0]            M_RRESP;
  logic                  M_RVALID;
  logic                  M_RREADY;
  logic [ADDRESS-1:0]    M_AWADDR;
  logic                  M_AWVALID;
  logic                  M_AWREADY;
  logic [DATA_WIDTH-1:0] M_WDATA;
  logic [STRB_W-1:0]     M_WSTRB;
  logic                  M_WVALID;
  logic                  M_WREADY;
  logic [1:0]            M_BRESP;
  logic                  M_BVALID;
  logic                  M_BREADY;

  modport master (
    output M_ARADDR, M_ARVALID, M_RREADY, M_AWADDR, M_AWVALID,
           M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
    input  M_ARREADY, M_RDATA, M_RRESP, M_RVALID, M_AWREADY,
           M_WREADY, M_BRESP, M_BVALID
  );

  modport slave (
    input  M_ARADDR, M_ARVALID, M_RREADY, M_AWADDR, M_AWVALID,
           M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
    output M_ARREADY, M_RDATA, M_RRESP, M_RVALID, M_AWREADY,
           M_WREADY, M_BRESP, M_BVALID
  );
endinterface

// File: rtl/axi4_lite_master_gen2.sv
// Single-outstanding request/response to AXI4-Lite master with an
// independent AW/W write path, response pass-through and a stall watchdog.
module axi4_lite_master_gen2 #(
  parameter int ADDRESS        = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESS-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    timeout,
  axi4_lite_master_gen2_if.master m_axi
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  awvalid_q, awvalid_d;
  logic [ADDRESS-1:0]    awaddr_q, awaddr_d;
  logic                  wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDRESS-1:0]    araddr_q, araddr_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  timeout_q, timeout_d;
  logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic [WD_W-1:0]       wd_inc;
  logic                  accept;
  logic                  busy;

  assign accept = req_valid && req_ready_q;
  assign busy   = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                  (state_q == S_RADDR) || (state_q == S_RDATA);
  assign wd_inc = wd_cnt_q + WD_W'(1);

  // Next-state, channel and watchdog logic; payloads are zeroed whenever
  // their VALID is dropped so the bus never shows stale data.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    awaddr_d    = awaddr_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    timeout_d   = timeout_q;
    wd_cnt_d    = wd_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wd_cnt_d  = '0;
          timeout_d = 1'b0;
          if (req_write) begin
            state_d   = S_WRITE;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awvalid_d = 1'b1;
            awaddr_d  = req_addr;
            wvalid_d  = 1'b1;
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
            araddr_d  = req_addr;
          end
        end
      end
      S_WRITE: begin
        if (awvalid_q && m_axi.M_AWREADY) begin
          awvalid_d = 1'b0;
          awaddr_d  = '0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axi.M_WREADY) begin
          wvalid_d = 1'b0;
          wdata_d  = '0;
          wstrb_d  = '0;
          w_done_d = 1'b1;
        end
        // BREADY rises in the first cycle both halves are known complete.
        if (aw_done_d && w_done_d) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        if (m_axi.M_BVALID) begin
          state_d     = S_RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi.M_BRESP;
        end
      end
      S_RADDR: begin
        if (m_axi.M_ARREADY) begin
          state_d   = S_RDATA;
          arvalid_d = 1'b0;
          araddr_d  = '0;
          rready_d  = 1'b1;
        end
      end
      S_RDATA: begin
        if (m_axi.M_RVALID) begin
          state_d     = S_RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi.M_RDATA;
          rsp_resp_d  = m_axi.M_RRESP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Saturating stall counter; the flag only reports, it never aborts.
    if ((TIMEOUT_CYCLES != 0) && busy && (wd_cnt_q != WD_LIMIT)) begin
      wd_cnt_d = wd_inc;
      if (wd_inc == WD_LIMIT) timeout_d = 1'b1;
    end

    req_ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs; reset drops every output at once.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      timeout_q   <= 1'b0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      timeout_q   <= timeout_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_write       = rsp_write_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_resp        = rsp_resp_q;
  assign timeout         = timeout_q;
  assign m_axi.M_AWVALID = awvalid_q;
  assign m_axi.M_AWADDR  = awaddr_q;
  assign m_axi.M_WVALID  = wvalid_q;
  assign m_axi.M_WDATA   = wdata_q;
  assign m_axi.M_WSTRB   = wstrb_q;
  assign m_axi.M_BREADY  = bready_q;
  assign m_axi.M_ARVALID = arvalid_q;
  assign m_axi.M_ARADDR  = araddr_q;
  assign m_axi.M_RREADY  = rready_q;
endmodule

// File: tb/tb_axi4_lite_master_gen2.sv
// Bench for axi4_lite_master_gen2: a 32-bit instance with a 16-cycle
// watchdog driven from a vector table, plus a 64-bit instance and
// hand-written reset sequences.
module tb_axi4_lite_master_gen2;
  logic ACLK;
  logic ARESETN;

  // 32-bit instance signals
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout;

  // 64-bit instance signals
  logic        req_valid64, req_ready64, req_write64;
  logic [31:0] req_addr64;
  logic [63:0] req_wdata64;
  logic [7:0]  req_wstrb64;
  logic        rsp_valid64, rsp_ready64, rsp_write64;
  logic [63:0] rsp_rdata64;
  logic [1:0]  rsp_resp64;
  logic        timeout64;

  int checks;
  int failures;

  axi4_lite_master_gen2_if #(.ADDRESS(32), .DATA_WIDTH(32)) ax32 ();
  axi4_lite_master_gen2_if #(.ADDRESS(32), .DATA_WIDTH(64)) ax64 ();

  axi4_lite_master_gen2 #(.ADDRESS(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) u_dut32 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
    .m_axi(ax32)
  );

  axi4_lite_master_gen2 #(.ADDRESS(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(1024)) u_dut64 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_write(req_write64),
    .req_addr(req_addr64), .req_wdata(req_wdata64), .req_wstrb(req_wstrb64),
    .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready64), .rsp_write(rsp_write64),
    .rsp_rdata(rsp_rdata64), .rsp_resp(rsp_resp64), .timeout(timeout64),
    .m_axi(ax64)
  );

  // Clock
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_hold;   // cycles AWVALID is high up to and including its handshake
    int          w_hold;
    int          ar_hold;
    int          r_hold;    // cycles RREADY is high up to and including the R handshake
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          stall;     // cycles rsp_ready stays low while rsp_valid is high
    int          exp_lat;   // cycle after acceptance in which rsp_valid first appears
    logic [31:0] exp_rdata;
    int          exp_to;    // cycle in which timeout first appears, 0 = never
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_slave32();
    ax32.M_AWREADY = 1'b0; ax32.M_WREADY = 1'b0;
    ax32.M_BVALID = 1'b0;  ax32.M_BRESP = 2'b00;
    ax32.M_ARREADY = 1'b0; ax32.M_RVALID = 1'b0;
    ax32.M_RDATA = 32'h0;  ax32.M_RRESP = 2'b00;
  endtask

  task automatic clear_slave64();
    ax64.M_AWREADY = 1'b0; ax64.M_WREADY = 1'b0;
    ax64.M_BVALID = 1'b0;  ax64.M_BRESP = 2'b00;
    ax64.M_ARREADY = 1'b0; ax64.M_RVALID = 1'b0;
    ax64.M_RDATA = 64'h0;  ax64.M_RRESP = 2'b00;
  endtask

  function automatic logic any_out32();
    return |{req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, timeout,
             ax32.M_ARADDR, ax32.M_ARVALID, ax32.M_RREADY, ax32.M_AWADDR,
             ax32.M_AWVALID, ax32.M_WDATA, ax32.M_WSTRB, ax32.M_WVALID, ax32.M_BREADY};
  endfunction

  function automatic logic any_out64();
    return |{req_ready64, rsp_valid64, rsp_write64, rsp_rdata64, rsp_resp64, timeout64,
             ax64.M_ARADDR, ax64.M_ARVALID, ax64.M_RREADY, ax64.M_AWADDR,
             ax64.M_AWVALID, ax64.M_WDATA, ax64.M_WSTRB, ax64.M_WVALID, ax64.M_BREADY};
  endfunction

  // Driver plus reactive slave for one vector on the 32-bit instance.
  // Entered and left at a falling edge; all sampling happens there.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc, aw_seen, w_seen, ar_seen, r_seen, b_seen, lat, to_cyc, stall_left;
    logic done, aw_done, w_done, aw_hs, w_hs;
    logic early_bready, bad_zero, rr_bad, unstable;
    logic [31:0] hs_awaddr, hs_wdata, hs_araddr, rsp_rdata0;
    logic [3:0]  hs_wstrb;
    logic [1:0]  rsp_resp0;
    logic        rsp_write0;
    cyc = 0; aw_seen = 0; w_seen = 0; ar_seen = 0; r_seen = 0; b_seen = 0;
    lat = 0; to_cyc = 0; stall_left = 0;
    done = 0; aw_done = 0; w_done = 0;
    early_bready = 0; bad_zero = 0; rr_bad = 0; unstable = 0;
    hs_awaddr = 0; hs_wdata = 0; hs_araddr = 0; hs_wstrb = 0;
    rsp_rdata0 = 0; rsp_resp0 = 0; rsp_write0 = 0;

    check($sformatf("v%0d_req_ready_before", idx), req_ready, 1'b1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_wstrb = v.strb;
    @(posedge ACLK);
    @(negedge ACLK);
    req_valid = 1'b0; req_write = 1'b0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    cyc = 1;
    while (!done && cyc <= 100) begin
      clear_slave32();
      // Stray responses on the channel not in use must be ignored.
      if (!v.wr) begin
        ax32.M_BVALID = 1'b1; ax32.M_BRESP = 2'b11;
      end else begin
        ax32.M_RVALID = 1'b1; ax32.M_RDATA = 32'hFFFF_FFFF; ax32.M_RRESP = 2'b11;
      end
      if (req_ready) rr_bad = 1'b1;
      if (timeout && to_cyc == 0) to_cyc = cyc;
      if (!ax32.M_AWVALID && ax32.M_AWADDR != 0) bad_zero = 1'b1;
      if (!ax32.M_WVALID && (ax32.M_WDATA != 0 || ax32.M_WSTRB != 0)) bad_zero = 1'b1;
      if (!ax32.M_ARVALID && ax32.M_ARADDR != 0) bad_zero = 1'b1;
      if (ax32.M_BREADY && !(aw_done && w_done)) early_bready = 1'b1;
      aw_hs = 1'b0; w_hs = 1'b0;
      if (ax32.M_AWVALID) begin
        aw_seen++;
        if (aw_seen == v.aw_hold) begin
          ax32.M_AWREADY = 1'b1; hs_awaddr = ax32.M_AWADDR; aw_hs = 1'b1;
        end
      end
      if (ax32.M_WVALID) begin
        w_seen++;
        if (w_seen == v.w_hold) begin
          ax32.M_WREADY = 1'b1; hs_wdata = ax32.M_WDATA; hs_wstrb = ax32.M_WSTRB; w_hs = 1'b1;
        end
      end
      if (aw_hs) aw_done = 1'b1;
      if (w_hs) w_done = 1'b1;
      if (ax32.M_ARVALID) begin
        ar_seen++;
        if (ar_seen == v.ar_hold) begin
          ax32.M_ARREADY = 1'b1; hs_araddr = ax32.M_ARADDR;
        end
      end
      if (ax32.M_BREADY) begin
        b_seen++;
        ax32.M_BVALID = 1'b1; ax32.M_BRESP = v.resp;
      end
      if (ax32.M_RREADY) begin
        r_seen++;
        if (r_seen == v.r_hold) begin
          ax32.M_RVALID = 1'b1; ax32.M_RDATA = v.rdata; ax32.M_RRESP = v.resp;
        end
      end
      if (rsp_valid) begin
        if (lat == 0) begin
          lat = cyc; rsp_write0 = rsp_write; rsp_rdata0 = rsp_rdata;
          rsp_resp0 = rsp_resp; stall_left = v.stall;
        end else if (rsp_write !== rsp_write0 || rsp_rdata !== rsp_rdata0 ||
                     rsp_resp !== rsp_resp0) begin
          unstable = 1'b1;
        end
        if (stall_left == 0) begin
          rsp_ready = 1'b1; done = 1'b1;
        end else begin
          stall_left--;
        end
      end else if (lat != 0) begin
        unstable = 1'b1;
      end
      @(posedge ACLK);
      @(negedge ACLK);
      cyc++;
    end
    rsp_ready = 1'b0;
    clear_slave32();

    check($sformatf("v%0d_completed", idx), done, 1'b1);
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_timeout_cycle", idx), to_cyc, v.exp_to);
    check($sformatf("v%0d_rsp_write", idx), rsp_write0, v.wr);
    check($sformatf("v%0d_rsp_rdata", idx), rsp_rdata0, v.exp_rdata);
    check($sformatf("v%0d_rsp_resp", idx), rsp_resp0, v.resp);
    check($sformatf("v%0d_awaddr", idx), hs_awaddr, v.wr ? v.addr : 32'h0);
    check($sformatf("v%0d_wdata", idx), hs_wdata, v.wr ? v.wdata : 32'h0);
    check($sformatf("v%0d_wstrb", idx), hs_wstrb, v.wr ? v.strb : 4'h0);
    check($sformatf("v%0d_araddr", idx), hs_araddr, v.wr ? 32'h0 : v.addr);
    check($sformatf("v%0d_awvalid_cycles", idx), aw_seen, v.aw_hold);
    check($sformatf("v%0d_wvalid_cycles", idx), w_seen, v.w_hold);
    check($sformatf("v%0d_arvalid_cycles", idx), ar_seen, v.ar_hold);
    check($sformatf("v%0d_rready_cycles", idx), r_seen, v.r_hold);
    check($sformatf("v%0d_bready_cycles", idx), b_seen, v.wr ? 1 : 0);
    check($sformatf("v%0d_bready_early", idx), early_bready, 1'b0);
    check($sformatf("v%0d_payload_not_zero", idx), bad_zero, 1'b0);
    check($sformatf("v%0d_req_ready_busy", idx), rr_bad, 1'b0);
    check($sformatf("v%0d_rsp_unstable", idx), unstable, 1'b0);
    check($sformatf("v%0d_req_ready_after", idx), req_ready, 1'b1);
    check($sformatf("v%0d_rsp_valid_after", idx), rsp_valid, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    //          wr    addr          wdata         strb aw w  ar  r  resp   rdata          stall lat exp_rdata     to
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1, 0,  0, 2'b00, 32'h0,         0,  3, 32'h0,         0};
    vecs[1] = '{1'b1, 32'h0000_0014, 32'hA5A5_0001, 4'h3, 5, 1, 0,  0, 2'b00, 32'h0,         0,  7, 32'h0,         0};
    vecs[2] = '{1'b1, 32'h0000_0018, 32'h0F0F_0F0F, 4'hC, 1, 5, 0,  0, 2'b10, 32'h0,         0,  7, 32'h0,         0};
    vecs[3] = '{1'b1, 32'h0000_001C, 32'h1111_2222, 4'h5, 3, 3, 0,  0, 2'b11, 32'h0,         0,  5, 32'h0,         0};
    vecs[4] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 1,  1, 2'b10, 32'h1234_5678, 0,  3, 32'h1234_5678, 0};
    vecs[5] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 0, 0, 3,  2, 2'b11, 32'hCAFE_F00D, 10, 6, 32'hCAFE_F00D, 0};
    vecs[6] = '{1'b1, 32'h0000_0028, 32'h1122_3344, 4'hF, 1, 1, 0,  0, 2'b01, 32'h0,         0,  3, 32'h0,         0};
    vecs[7] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 0, 0, 20, 1, 2'b00, 32'h55AA_55AA, 0, 22, 32'h55AA_55AA, 17};
    vecs[8] = '{1'b1, 32'h0000_0034, 32'h0BAD_F00D, 4'h9, 1, 1, 0,  0, 2'b00, 32'h0,         0,  3, 32'h0,         0};

    // Reset phase
    ARESETN = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
    req_valid64 = 0; req_write64 = 0; req_addr64 = 0; req_wdata64 = 0; req_wstrb64 = 0; rsp_ready64 = 0;
    clear_slave32();
    clear_slave64();
    repeat (3) @(negedge ACLK);
    check("reset_outputs32", any_out32(), 1'b0);
    check("reset_outputs64", any_out64(), 1'b0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("post_reset_req_ready32", req_ready, 1'b1);
    check("post_reset_req_ready64", req_ready64, 1'b1);

    // Table-driven transactions, back to back
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    check("timeout_sticky_in_idle", timeout, 1'b1);
    run_vec(8, vecs[8]);
    check("timeout_cleared_by_accept", timeout, 1'b0);

    // 64-bit write, zero-wait slave, lower-word strobes
    req_valid64 = 1'b1; req_write64 = 1'b1; req_addr64 = 32'h0000_0040;
    req_wdata64 = 64'h0123_4567_89AB_CDEF; req_wstrb64 = 8'h0F;
    @(posedge ACLK);
    @(negedge ACLK);
    req_valid64 = 1'b0; req_write64 = 0; req_addr64 = 0; req_wdata64 = 0; req_wstrb64 = 0;
    check("w64_valids", {ax64.M_AWVALID, ax64.M_WVALID}, 2'b11);
    check("w64_awaddr", ax64.M_AWADDR, 32'h0000_0040);
    check("w64_wdata", ax64.M_WDATA, 64'h0123_4567_89AB_CDEF);
    check("w64_wstrb", ax64.M_WSTRB, 8'h0F);
    check("w64_req_ready_busy", req_ready64, 1'b0);
    ax64.M_AWREADY = 1'b1; ax64.M_WREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    clear_slave64();
    check("w64_bready", ax64.M_BREADY, 1'b1);
    check("w64_valids_dropped", {ax64.M_AWVALID, ax64.M_WVALID}, 2'b00);
    check("w64_wdata_zeroed", ax64.M_WDATA, 64'h0);
    check("w64_rsp_early", rsp_valid64, 1'b0);
    ax64.M_BVALID = 1'b1; ax64.M_BRESP = 2'b00;
    @(posedge ACLK);
    @(negedge ACLK);
    clear_slave64();
    check("w64_rsp_valid", rsp_valid64, 1'b1);
    check("w64_rsp_write", rsp_write64, 1'b1);
    check("w64_rsp_rdata", rsp_rdata64, 64'h0);
    check("w64_rsp_resp", rsp_resp64, 2'b00);
    rsp_ready64 = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    rsp_ready64 = 1'b0;
    check("w64_req_ready_after", req_ready64, 1'b1);
    check("w64_rsp_valid_after", rsp_valid64, 1'b0);

    // Reset in WRESP on the 32-bit instance
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0050;
    req_wdata = 32'h7777_8888; req_wstrb = 4'hF;
    @(posedge ACLK);
    @(negedge ACLK);
    req_valid = 1'b0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    ax32.M_AWREADY = 1'b1; ax32.M_WREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    clear_slave32();
    check("rst_in_wresp_bready", ax32.M_BREADY, 1'b1);
    #2;
    ARESETN = 1'b0;
    #1;
    check("rst_async_outputs32", any_out32(), 1'b0);
    check("rst_async_outputs64", any_out64(), 1'b0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    ax32.M_BVALID = 1'b1; ax32.M_BRESP = 2'b10;
    @(negedge ACLK);
    check("rst_req_ready_after", req_ready, 1'b1);
    begin
      logic saw_rsp;
      saw_rsp = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (rsp_valid || ax32.M_BREADY) saw_rsp = 1'b1;
        @(negedge ACLK);
      end
      check("rst_no_response", saw_rsp, 1'b0);
    end
    clear_slave32();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_lite_master_gen2.md
# axi4_lite_master_gen2

Parametrised second-generation AXI4-Lite master that converts a single-outstanding request/response interface from the core into AXI4-Lite read and write transactions. AW and W channels complete independently, in either order. Byte strobes and slave responses (OKAY/SLVERR/DECERR) are passed through, and a stall watchdog is included. It sits between the core's load/store unit and the AXI4-Lite interconnect.

## Interface
- ADDRESS, 32, address width
- DATA_WIDTH, 32, data width; 32 or 64 only; STRB_W = DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; 0 disables the watchdog
- ACLK  in  1  single clock; all logic on the rising edge
- ARESETN  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted; high only in IDLE with ARESETN high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDRESS  byte address
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  STRB_W  byte enables for writes
- rsp_valid  out  1  response valid; held until rsp_ready
- rsp_ready  in  1  response accepted
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  RRESP or BRESP
- timeout  out  1  sticky watchdog flag
- M_ARADDR/M_ARVALID/M_ARREADY, M_RDATA/M_RRESP/M_RVALID/M_RREADY, M_AWADDR/M_AWVALID/M_AWREADY, M_WDATA/M_WSTRB/M_WVALID/M_WREADY, M_BRESP/M_BVALID/M_BREADY  standard AXI4-Lite channels at ADDRESS/DATA_WIDTH/STRB_W

## Operation
- States:
  - IDLE
  - WRITE: AW and/or W pending
  - WRESP
  - RADDR
  - RDATA
  - RSP
- IDLE: the request is captured on req_valid && req_ready (address, data and strobes registered). Next state is WRITE if req_write, otherwise RADDR.
- WRITE: M_AWVALID and M_WVALID both rise on entry.
  - Each VALID drops independently the cycle after its own handshake. Handshakes may occur in the same cycle or in either order.
  - Separate aw_done and w_done flags track progress.
  - Move to WRESP the cycle after both flags are set.
- WRESP: M_BREADY is high. On the B handshake, capture BRESP and go to RSP.
- RADDR: M_ARVALID is high. On the AR handshake, go to RDATA.
- RDATA: M_RREADY is high. On the R handshake, capture RDATA and RRESP and go to RSP.
- RSP: rsp_valid is high with the captured fields. On rsp_valid && rsp_ready, go to IDLE.
- All AXI VALID/READY outputs come from flops. ADDR/DATA/STRB are stable while VALID is high and are 0 while VALID is low.
- Once raised, a VALID is never withdrawn before its handshake, including on watchdog expiry.
- SLVERR/DECERR responses are forwarded unchanged. No retry is performed.
- Watchdog:
  - The counter clears on request acceptance and increments every cycle in WRITE, WRESP, RADDR and RDATA.
  - When the count reaches TIMEOUT_CYCLES (non-zero), timeout is set. The transaction keeps waiting.
  - timeout clears on the next request acceptance.
  - The counter saturates and does not wrap.
- Slave inputs outside the expected state are ignored (e.g. BVALID in RADDR, RVALID in WRITE).

## Timing
- Reset (asynchronous assert, synchronous deassert at the next ACLK edge):
  - state = IDLE.
  - Every output is 0, including req_ready, rsp_valid, timeout, all VALID/READY outputs and all ADDR/DATA/STRB outputs.
- Reset mid-transaction aborts immediately. Outputs go to 0 asynchronously and no response is produced.
- Request accepted at edge N: AXI VALIDs are high in cycle N+1.
- Zero-wait slave, write:
  - AW/W handshake at N+1.
  - M_BREADY at N+2; BVALID at N+2 gives rsp_valid at N+3.
  - Minimum latency is 3 cycles.
- Zero-wait slave, read:
  - AR handshake at N+1.
  - RREADY at N+2; R handshake at N+2 gives rsp_valid at N+3.
- req_ready is low from the acceptance edge until the cycle after the rsp handshake. Back-to-back throughput is one transaction per 4 cycles minimum.
- rsp_ready held low: rsp_valid and its fields stay stable indefinitely, and no new request is accepted.
- Watchdog: timeout rises exactly TIMEOUT_CYCLES cycles after the first cycle in WRITE/RADDR.

## Test plan
- Write 0x0000_0010, data 0xDEAD_BEEF, strb 0xF, zero-wait slave -> AW/W in the same cycle carry these values; rsp_valid 3 cycles after acceptance with rsp_write=1 and rsp_resp=00.
- Write with AWREADY delayed 5 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID is held 5 cycles, BREADY rises only after both handshakes; repeat with W delayed instead.
- Read 0x0000_0020 where the slave returns 0x1234_5678 with RRESP=10 -> rsp_rdata=0x1234_5678, rsp_resp=10, rsp_write=0.
- rsp_ready held low for 10 cycles -> rsp fields stable and req_ready=0 throughout; new request accepted the cycle after rsp_ready rises.
- TIMEOUT_CYCLES=16 with ARREADY stuck low -> ARVALID stays high and timeout=1 after 16 cycles; releasing ARREADY completes the read normally and timeout clears on the next acceptance.
- ARESETN pulsed low while in WRESP -> all outputs 0 immediately, no rsp_valid, req_ready=1 the first cycle after deassertion; DATA_WIDTH=64 variant repeats the write test with strb 0x0F.
